rst_seq_ctrl: RTL and testbench

Parametrised reset sequencer and run monitor for the CPU top level and its bench. It turns the single system reset into a configurable hold period, then releases N reset domains in a fixed staggered order. After all domains are released it counts run cycles and can optionally re-assert reset through a heartbeat watchdog. It sits between the clock/reset source and the CPU core, memories and peripherals.

---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/rst_seq_ctrl_sat_counter.sv | 25 ++
 rtl/rst_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: the sequencer state
// encoding and a width helper for its internal counters.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // Bits needed to hold the values 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear has priority over enable; the count sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Clear, count, or hold at the saturation value.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer and run monitor.
// Holds all reset domains for HOLD_CYCLES after the system reset drops,
// releases them one by one (bit 0 first) every STAGE_GAP cycles, then counts
// run cycles. soft_rst_req re-runs the whole sequence from HOLD.
// Optional feature macro: RST_SEQ_WDOG_EN adds a heartbeat watchdog that
// re-enters HOLD after WDOG_CYCLES heartbeat-free cycles in RUN. Without it
// heartbeat is ignored and wdog_fire stays low.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 5,
  parameter int STAGE_GAP   = 2,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                soft_rst_req,
  input  logic                heartbeat,
  output logic [CHANNELS-1:0] rst_out,
  output logic                all_released,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic                wdog_fire
);

  localparam int HOLD_W = clog2(HOLD_CYCLES);
  localparam int GAP_W  = clog2(STAGE_GAP);
  localparam int IDX_W  = clog2(CHANNELS);

  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0]    IDX_FIRST = IDX_W'(1);
  localparam logic [CHANNELS-1:0] CH_ONE    = CHANNELS'(1);

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [CHANNELS-1:0] r_rst_out;
  logic                r_all_rel;

  state_t              w_state_nxt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic [GAP_W-1:0]    w_gap_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [CHANNELS-1:0] w_rst_out_nxt;
  logic                w_all_rel_nxt;

  logic                w_wdog_expire;
  logic                w_go_hold;
  logic                w_in_run;

  assign w_in_run = (r_state == RUN);

`ifdef RST_SEQ_WDOG_EN
  localparam int WDOG_W = clog2(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] w_wdog_cnt;
  logic              r_wdog_fire;

  // Heartbeat-free cycle count; only advances in RUN and restarts on any
  // heartbeat or when the sequence is restarted.
  sat_counter #(
    .WIDTH (WDOG_W)
  ) u_wdog_cnt (
    .clk   (clk),
    .i_clr (rst | w_go_hold | ~w_in_run | heartbeat),
    .i_en  (1'b1),
    .o_cnt (w_wdog_cnt)
  );

  assign w_wdog_expire = w_in_run && !heartbeat && (w_wdog_cnt == WDOG_LAST);

  // One-cycle pulse registered at the same edge that re-enters HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog_fire <= 1'b0;
    end else begin
      r_wdog_fire <= w_wdog_expire;
    end
  end

  assign wdog_fire = r_wdog_fire;
`else
  logic w_unused_heartbeat;

  assign w_unused_heartbeat = heartbeat;
  assign w_wdog_expire      = 1'b0;
  assign wdog_fire          = 1'b0;
`endif

  // A watchdog expiry and a soft request both restart the sequence; both may
  // coincide, which still produces a single HOLD entry.
  assign w_go_hold = soft_rst_req | w_wdog_expire;

  // Next-state and next-output logic for the HOLD/RELEASE/RUN sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_idx_nxt     = r_idx;
    w_rst_out_nxt = r_rst_out;
    w_all_rel_nxt = r_all_rel;

    if (w_go_hold) begin
      w_state_nxt   = HOLD;
      w_hold_nxt    = '0;
      w_gap_nxt     = '0;
      w_idx_nxt     = '0;
      w_rst_out_nxt = '1;
      w_all_rel_nxt = 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          w_hold_nxt = r_hold_cnt + 1'b1;
          if (r_hold_cnt == HOLD_LAST) begin
            w_hold_nxt       = '0;
            w_rst_out_nxt[0] = 1'b0;
            if (CHANNELS == 1) begin
              w_state_nxt   = RUN;
              w_all_rel_nxt = 1'b1;
            end else begin
              w_state_nxt = RELEASE;
              w_gap_nxt   = '0;
              w_idx_nxt   = IDX_FIRST;
            end
          end
        end

        RELEASE: begin
          w_gap_nxt = r_gap_cnt + 1'b1;
          if (r_gap_cnt == GAP_LAST) begin
            w_gap_nxt     = '0;
            w_idx_nxt     = r_idx + 1'b1;
            w_rst_out_nxt = r_rst_out & ~(CH_ONE << r_idx);
            if (r_idx == IDX_LAST) begin
              w_state_nxt   = RUN;
              w_all_rel_nxt = 1'b1;
            end
          end
        end

        RUN: begin
          w_state_nxt = RUN;
        end

        default: begin
          w_state_nxt   = HOLD;
          w_hold_nxt    = '0;
          w_gap_nxt     = '0;
          w_idx_nxt     = '0;
          w_rst_out_nxt = '1;
          w_all_rel_nxt = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs; system reset forces HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HOLD;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_idx      <= '0;
      r_rst_out  <= '1;
      r_all_rel  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_idx      <= w_idx_nxt;
      r_rst_out  <= w_rst_out_nxt;
      r_all_rel  <= w_all_rel_nxt;
    end
  end

  // Run-cycle counter: counts while in RUN, zeroed on every restart.
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .i_clr (rst | w_go_hold),
    .i_en  (w_in_run),
    .o_cnt (cycle_cnt)
  );

  assign rst_out      = r_rst_out;
  assign all_released = r_all_rel;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl: a default-parameter instance (watchdog of 8
// cycles when RST_SEQ_WDOG_EN is defined) and a single-domain instance with
// HOLD_CYCLES=1 and a 4-bit run counter, sharing all inputs.
module tb_rst_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        soft_rst_req = 1'b0;
  logic        heartbeat = 1'b0;

  logic [3:0]  d_rst_out;
  logic        d_rel;
  logic [31:0] d_cnt;
  logic        d_fire;

  logic [0:0]  o_rst_out;
  logic        o_rel;
  logic [3:0]  o_cnt;
  logic        o_fire;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int fire_cnt = 0;

`ifdef RST_SEQ_WDOG_EN
  localparam logic EXP_FIRE = 1'b1;
`else
  localparam logic EXP_FIRE = 1'b0;
`endif

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .CHANNELS    (4),
    .HOLD_CYCLES (5),
    .STAGE_GAP   (2),
    .CNT_W       (32),
    .WDOG_CYCLES (8)
  ) u_def (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .heartbeat    (heartbeat),
    .rst_out      (d_rst_out),
    .all_released (d_rel),
    .cycle_cnt    (d_cnt),
    .wdog_fire    (d_fire)
  );

  rst_seq_ctrl #(
    .CHANNELS    (1),
    .HOLD_CYCLES (1),
    .STAGE_GAP   (2),
    .CNT_W       (4),
    .WDOG_CYCLES (1000)
  ) u_one (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .heartbeat    (heartbeat),
    .rst_out      (o_rst_out),
    .all_released (o_rel),
    .cycle_cnt    (o_cnt),
    .wdog_fire    (o_fire)
  );

  always @(negedge clk) begin
    if (d_fire === 1'b1) fire_cnt++;
  end

  typedef struct {
    int          e;
    logic [3:0]  d_rst;
    logic        d_rel;
    logic [31:0] d_cnt;
    logic        o_rst;
    logic        o_rel;
    logic [3:0]  o_cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic tick_to(input int e);
    while (edge_no < e) tick();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_no);
    end
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, " d_rst_out"}, 64'(d_rst_out), 64'hF);
    chk({nm, " d_rel"},     64'(d_rel),     64'h0);
    chk({nm, " d_cnt"},     64'(d_cnt),     64'h0);
    chk({nm, " d_fire"},    64'(d_fire),    64'h0);
    chk({nm, " o_rst_out"}, 64'(o_rst_out), 64'h1);
    chk({nm, " o_rel"},     64'(o_rel),     64'h0);
    chk({nm, " o_cnt"},     64'(o_cnt),     64'h0);
    chk({nm, " o_fire"},    64'(o_fire),    64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //       edge  d_rst    rel  cnt  o_rst rel  cnt
    tbl[0]  = '{0,  4'b1111, 1'b0, 0, 1'b0, 1'b1, 4'd0};
    tbl[1]  = '{3,  4'b1111, 1'b0, 0, 1'b0, 1'b1, 4'd3};
    tbl[2]  = '{4,  4'b1110, 1'b0, 0, 1'b0, 1'b1, 4'd4};
    tbl[3]  = '{5,  4'b1110, 1'b0, 0, 1'b0, 1'b1, 4'd5};
    tbl[4]  = '{6,  4'b1100, 1'b0, 0, 1'b0, 1'b1, 4'd6};
    tbl[5]  = '{7,  4'b1100, 1'b0, 0, 1'b0, 1'b1, 4'd7};
    tbl[6]  = '{8,  4'b1000, 1'b0, 0, 1'b0, 1'b1, 4'd8};
    tbl[7]  = '{9,  4'b1000, 1'b0, 0, 1'b0, 1'b1, 4'd9};
    tbl[8]  = '{10, 4'b0000, 1'b1, 0, 1'b0, 1'b1, 4'd10};
    tbl[9]  = '{11, 4'b0000, 1'b1, 1, 1'b0, 1'b1, 4'd11};
    tbl[10] = '{15, 4'b0000, 1'b1, 5, 1'b0, 1'b1, 4'd15};
    tbl[11] = '{16, 4'b0000, 1'b1, 6, 1'b0, 1'b1, 4'd15};

    // Reset held for five edges.
    repeat (5) tick();
    chk_reset_state("reset");

    // Release reset: the next sampled edge is edge 0.
    rst = 1'b0;
    edge_no = -1;
    for (int i = 0; i < 12; i++) begin
      tick_to(tbl[i].e);
      chk($sformatf("e%0d d_rst_out", tbl[i].e), 64'(d_rst_out), 64'(tbl[i].d_rst));
      chk($sformatf("e%0d d_rel", tbl[i].e),     64'(d_rel),     64'(tbl[i].d_rel));
      chk($sformatf("e%0d d_cnt", tbl[i].e),     64'(d_cnt),     64'(tbl[i].d_cnt));
      chk($sformatf("e%0d d_fire", tbl[i].e),    64'(d_fire),    64'h0);
      chk($sformatf("e%0d o_rst_out", tbl[i].e), 64'(o_rst_out), 64'(tbl[i].o_rst));
      chk($sformatf("e%0d o_rel", tbl[i].e),     64'(o_rel),     64'(tbl[i].o_rel));
      chk($sformatf("e%0d o_cnt", tbl[i].e),     64'(o_cnt),     64'(tbl[i].o_cnt));
    end

`ifdef RST_SEQ_WDOG_EN
    // No heartbeat since RUN was entered at edge 10: expiry at edge 18.
    tick_to(17);
    chk("wd pre d_fire", 64'(d_fire), 64'h0);
    chk("wd pre d_cnt",  64'(d_cnt),  64'd7);
    tick_to(18);
    chk("wd d_fire",    64'(d_fire),    64'h1);
    chk("wd d_rst_out", 64'(d_rst_out), 64'hF);
    chk("wd d_rel",     64'(d_rel),     64'h0);
    chk("wd d_cnt",     64'(d_cnt),     64'h0);
    tick_to(19);
    chk("wd post d_fire",    64'(d_fire),    64'h0);
    chk("wd post d_rst_out", 64'(d_rst_out), 64'hF);
    tick_to(22);
    chk("wd rerun e22 d_rst_out", 64'(d_rst_out), 64'hF);
    tick_to(23);
    chk("wd rerun e23 d_rst_out", 64'(d_rst_out), 64'hE);
    tick_to(28);
    chk("wd rerun e28 d_rel", 64'(d_rel), 64'h0);
    tick_to(29);
    chk("wd rerun e29 d_rst_out", 64'(d_rst_out), 64'h0);
    chk("wd rerun e29 d_rel",     64'(d_rel),     64'h1);
`else
    tick_to(20);
    chk("nowd d_fire",    64'(d_fire),    64'h0);
    chk("nowd d_rst_out", 64'(d_rst_out), 64'h0);
    chk("nowd d_cnt",     64'(d_cnt),     64'd10);
    chk("nowd fire count", 64'(fire_cnt), 64'd0);
`endif
    chk("sat o_cnt", 64'(o_cnt), 64'd15);

    // System reset asserted while running.
    rst = 1'b1;
    tick();
    chk_reset_state("rst in run");
    rst = 1'b0;
    edge_no = -1;

    // Soft request sampled at edge 8 (mid-RELEASE).
    tick_to(7);
    chk("soft e7 d_rst_out", 64'(d_rst_out), 64'hC);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("soft e8 d_rst_out", 64'(d_rst_out), 64'hF);
    chk("soft e8 d_rel",     64'(d_rel),     64'h0);
    chk("soft e8 o_rst_out", 64'(o_rst_out), 64'h1);
    chk("soft e8 o_rel",     64'(o_rel),     64'h0);
    chk("soft e8 o_cnt",     64'(o_cnt),     64'h0);
    tick_to(9);
    chk("soft e9 o_rst_out", 64'(o_rst_out), 64'h0);
    chk("soft e9 o_rel",     64'(o_rel),     64'h1);
    tick_to(12);
    chk("soft e12 d_rst_out", 64'(d_rst_out), 64'hF);
    tick_to(13);
    chk("soft e13 d_rst_out", 64'(d_rst_out), 64'hE);
    tick_to(19);
    chk("soft e19 d_rst_out", 64'(d_rst_out), 64'h0);
    chk("soft e19 d_rel",     64'(d_rel),     64'h1);

    // Heartbeat every fourth cycle keeps the watchdog quiet.
    fire_cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      heartbeat = ((k % 4) == 3);
      tick();
    end
    heartbeat = 1'b0;
    chk("hb fire count", 64'(fire_cnt), 64'd0);
    chk("hb d_rel",      64'(d_rel),    64'h1);

    // Seven silent cycles, then soft request coinciding with expiry.
    repeat (7) tick();
    chk("coinc pre d_fire", 64'(d_fire), 64'h0);
    fire_cnt = 0;
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("coinc d_fire",    64'(d_fire),    64'(EXP_FIRE));
    chk("coinc d_rst_out", 64'(d_rst_out), 64'hF);
    chk("coinc d_rel",     64'(d_rel),     64'h0);
    chk("coinc d_cnt",     64'(d_cnt),     64'h0);
    tick();
    chk("coinc post d_fire",   64'(d_fire),   64'h0);
    chk("coinc fire count",    64'(fire_cnt), 64'(EXP_FIRE));
    repeat (3) tick();
    chk("coinc +4 d_rst_out", 64'(d_rst_out), 64'hF);
    tick();
    chk("coinc +5 d_rst_out", 64'(d_rst_out), 64'hE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
